seg_scan_capture: RTL and testbench

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

---
 rtl/seg_scan_capture.sv | 180 ++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// Captures a multiplexed 5-digit 7-segment display scan into a decoded frame.
// Digits are accepted after STABLE_CYCLES identical one-hot samples; a watchdog flags a lost scan.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 250000,
  parameter bit          SEL_ACTIVE_LOW = 1'b0,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  SEG_SEL,
  input  logic [7:0]  SEG_DATA,
  input  logic        frame_ack,
  output logic [19:0] digits,
  output logic [4:0]  dp_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic        scan_lost
);

  localparam int unsigned N_DIG   = 5;
  localparam int unsigned SEL_W   = 5;
  localparam int unsigned DAT_W   = 8;
  localparam int unsigned STAB_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {ST_WAIT, ST_HOLD} state_t;

  logic [SEL_W-1:0]       w_sel_norm;
  logic [DAT_W-1:0]       w_dat_norm;
  logic [SEL_W-1:0]       r_sel_m, r_sel_s;
  logic [DAT_W-1:0]       r_dat_m, r_dat_s;
  logic [SEL_W+DAT_W-1:0] r_prev;
  logic [SEL_W+DAT_W-1:0] w_samp;
  logic [STAB_W-1:0]      r_stab, w_stab_nxt;
  logic [WD_W-1:0]        r_wd;
  state_t                 r_state;
  logic                   w_same, w_onehot, w_capture, w_full, w_wd_fire;
  logic [2:0]             w_idx;
  logic [3:0]             w_code;
  logic                   w_bad;
  logic [19:0]            r_sh_dig;
  logic [N_DIG-1:0]       r_sh_dp, r_seen, r_inv;

  // Normalize polarity so every downstream bit is active-high
  assign w_sel_norm = SEL_ACTIVE_LOW ? ~SEG_SEL  : SEG_SEL;
  assign w_dat_norm = SEG_ACTIVE_LOW ? ~SEG_DATA : SEG_DATA;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_m <= '0;
      r_sel_s <= '0;
      r_dat_m <= '0;
      r_dat_s <= '0;
    end else begin
      r_sel_m <= w_sel_norm;
      r_sel_s <= r_sel_m;
      r_dat_m <= w_dat_norm;
      r_dat_s <= r_dat_m;
    end
  end

  assign w_samp   = {r_sel_s, r_dat_s};
  assign w_same   = (w_samp == r_prev);
  assign w_onehot = (r_sel_s != '0) && ((r_sel_s & (r_sel_s - SEL_W'(1))) == '0);

  // Run length of the current sample; blanking or any change restarts it
  always_comb begin
    w_stab_nxt = '0;
    if (w_onehot && w_same) begin
      w_stab_nxt = (r_stab == STAB_MAX) ? STAB_MAX : r_stab + STAB_W'(1);
    end
  end

  assign w_capture = (r_state == ST_WAIT) && w_onehot && (w_stab_nxt == STAB_MAX);
  assign w_full    = &r_seen;
  assign w_wd_fire = !w_capture && (r_wd == WD_LAST);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_DIG; i++) begin
      if (r_sel_s[i]) w_idx = 3'(i);
    end
  end

  always_comb begin
    w_bad  = 1'b0;
    w_code = 4'hE;
    case (r_dat_s[6:0])
      7'h3F:   w_code = 4'h0;
      7'h06:   w_code = 4'h1;
      7'h5B:   w_code = 4'h2;
      7'h4F:   w_code = 4'h3;
      7'h66:   w_code = 4'h4;
      7'h6D:   w_code = 4'h5;
      7'h7D:   w_code = 4'h6;
      7'h07:   w_code = 4'h7;
      7'h7F:   w_code = 4'h8;
      7'h6F:   w_code = 4'h9;
      7'h00:   w_code = 4'hF;
      default: w_bad  = 1'b1;
    endcase
  end

  // Capture state machine and stability tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_WAIT;
      r_stab  <= '0;
      r_prev  <= '0;
    end else begin
      r_stab <= w_stab_nxt;
      r_prev <= w_samp;
      case (r_state)
        ST_WAIT: if (w_capture) r_state <= ST_HOLD;
        ST_HOLD: if (!w_same)   r_state <= ST_WAIT;
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  // Shadow frame; a completed frame or a lost scan restarts collection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_dig <= '0;
      r_sh_dp  <= '0;
      r_seen   <= '0;
      r_inv    <= '0;
    end else begin
      if (w_full || w_wd_fire) begin
        r_seen <= '0;
        r_inv  <= '0;
      end
      if (w_capture) begin
        r_sh_dig[{w_idx, 2'b00} +: 4] <= w_code;
        r_sh_dp[w_idx]                <= r_dat_s[7];
        r_seen[w_idx]                 <= 1'b1;
        r_inv[w_idx]                  <= w_bad;
      end
    end
  end

  // Output frame and handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits      <= '0;
      dp_out      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else if (w_full) begin
      digits      <= r_sh_dig;
      dp_out      <= r_sh_dp;
      frame_err   <= |r_inv;
      frame_valid <= 1'b1;
      if (frame_valid && !frame_ack) overrun <= 1'b1;
    end else if (frame_ack) begin
      frame_valid <= 1'b0;
    end
  end

  // Watchdog: saturating count of cycles since the last capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd      <= '0;
      scan_lost <= 1'b0;
    end else if (w_capture) begin
      r_wd      <= '0;
      scan_lost <= 1'b0;
    end else if (r_wd != WD_MAX) begin
      r_wd <= r_wd + WD_W'(1);
      if (w_wd_fire) scan_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomized and directed bench for seg_scan_capture against a segment-level reference model.
module tb_seg_scan_capture;
  localparam int STB = 4;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  SEG_SEL = '0;
  logic [7:0]  SEG_DATA = '0;
  logic        frame_ack = 1'b0;
  logic [19:0] digits;
  logic [4:0]  dp_out;
  logic        frame_valid, frame_err, overrun, scan_lost;

  seg_scan_capture #(
    .STABLE_CYCLES(STB), .TIMEOUT_CYCLES(TMO), .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .SEG_SEL(SEG_SEL), .SEG_DATA(SEG_DATA), .frame_ack(frame_ack),
    .digits(digits), .dp_out(dp_out), .frame_valid(frame_valid), .frame_err(frame_err),
    .overrun(overrun), .scan_lost(scan_lost)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model state
  logic [6:0]  pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [3:0]  m_sh [5];
  bit          m_dp [5];
  bit          m_inv [5];
  bit          m_seen [5];
  logic [19:0] m_digits;
  logic [4:0]  m_dpo;
  bit          m_valid, m_err, m_ovr;
  int          m_last;
  logic [12:0] last_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic void decode(input logic [7:0] d, output logic [3:0] v, output bit bad);
    v = 4'hE;
    bad = 1'b1;
    if (d[6:0] == 7'h00) begin
      v = 4'hF;
      bad = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      if (pat[k] == d[6:0]) begin
        v = 4'(k);
        bad = 1'b0;
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_sh[i] = '0; m_dp[i] = 0; m_inv[i] = 0; m_seen[i] = 0;
    end
    m_digits = '0; m_dpo = '0; m_valid = 0; m_err = 0; m_ovr = 0;
    m_last = cyc;
    last_drv = '0;
  endtask

  // Discard the partial frame if the watchdog expired on or before edge t
  task automatic expire(input int t);
    if (t - m_last >= TMO) begin
      for (int i = 0; i < 5; i++) begin
        m_seen[i] = 0; m_inv[i] = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    SEG_SEL = '0; SEG_DATA = '0; frame_ack = 1'b0;
    repeat (3) tick();
    check("rst.digits", 32'(digits), 32'h0);
    check("rst.dp", 32'(dp_out), 32'h0);
    check("rst.valid", 32'(frame_valid), 32'h0);
    check("rst.err", 32'(frame_err), 32'h0);
    check("rst.ovr", 32'(overrun), 32'h0);
    check("rst.lost", 32'(scan_lost), 32'h0);
    reset = 1'b1;
    model_reset();
  endtask

  // Hold one {sel,data} value for len cycles and apply its effect to the model
  task automatic seg(input logic [4:0] sel, input logic [7:0] data, input int len,
                     input bit ack_first, input bit ack_load);
    int c0, cap, i;
    bit all, loaded;
    logic [3:0] v;
    bit bad;
    c0 = cyc;
    cap = c0 + STB + 2;
    SEG_SEL = sel; SEG_DATA = data; frame_ack = ack_first;
    for (int k = 1; k <= len; k++) begin
      tick();
      frame_ack = ack_load && (k == STB + 2);
    end
    frame_ack = 1'b0;
    loaded = 0;
    if (ack_first) m_valid = 0;
    if ($countones(sel) == 1 && len >= STB) begin
      expire(cap - 1);
      i = 0;
      for (int k = 0; k < 5; k++) if (sel[k]) i = k;
      decode(data, v, bad);
      m_sh[i] = v; m_dp[i] = data[7]; m_inv[i] = bad; m_seen[i] = 1;
      m_last = cap;
      all = 1;
      for (int k = 0; k < 5; k++) all &= m_seen[k];
      if (all) begin
        loaded = 1;
        if (m_valid && !ack_load) m_ovr = 1;
        m_valid = 1;
        m_err = 0;
        for (int k = 0; k < 5; k++) begin
          m_digits[4*k +: 4] = m_sh[k];
          m_dpo[k] = m_dp[k];
          m_err |= m_inv[k];
          m_seen[k] = 0; m_inv[k] = 0;
        end
      end
    end
    if (ack_load && !loaded) m_valid = 0;
    last_drv = {sel, data};
  endtask

  task automatic chk_all(input string tag);
    expire(cyc);
    check({tag, ".digits"}, 32'(digits), 32'(m_digits));
    check({tag, ".dp"}, 32'(dp_out), 32'(m_dpo));
    check({tag, ".valid"}, 32'(frame_valid), 32'(m_valid));
    check({tag, ".err"}, 32'(frame_err), 32'(m_err));
    check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    check({tag, ".lost"}, 32'(scan_lost), 32'((cyc - m_last) >= TMO));
  endtask

  task automatic scan5(input logic [39:0] d, input bit ack_last_load);
    for (int i = 0; i < 5; i++) seg(5'(1 << i), d[8*i +: 8], 10, 1'b0, (i == 4) && ack_last_load);
  endtask

  initial begin
    logic [39:0] fa, fb;
    logic [4:0]  sel;
    logic [7:0]  data;
    int len, kind, nocap, b0;
    bit capt;
    fa = {8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
    fb = {8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D};
    do_reset();

    // Basic frame
    scan5(fa, 1'b0);
    chk_all("basic");
    check("basic.const", 32'(digits), 32'h43210);
    check("basic.cerr", 32'(frame_err), 32'h0);
    seg(5'b0, 8'h00, 4, 1'b1, 1'b0);
    chk_all("ack");
    check("ack.cvalid", 32'(frame_valid), 32'h0);

    // Undecodable digit, then a too-short digit
    scan5({8'h66, 8'h4F, 8'h77, 8'h06, 8'h3F}, 1'b0);
    chk_all("bad");
    check("bad.nib", 32'(digits[11:8]), 32'hE);
    check("bad.cerr", 32'(frame_err), 32'h1);
    seg(5'b0, 8'h00, 3, 1'b1, 1'b0);
    seg(5'b00001, 8'h06, 3, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) seg(5'(1 << i), fa[8*i +: 8], 10, 1'b0, 1'b0);
    chk_all("short");
    check("short.cvalid", 32'(frame_valid), 32'h0);

    // Overrun, then acknowledged on the load cycle
    do_reset();
    scan5(fa, 1'b0);
    scan5(fb, 1'b0);
    chk_all("ovr");
    check("ovr.const", 32'(digits), 32'h98765);
    check("ovr.covr", 32'(overrun), 32'h1);
    do_reset();
    scan5(fa, 1'b0);
    scan5(fb, 1'b1);
    chk_all("ackld");
    check("ackld.covr", 32'(overrun), 32'h0);
    check("ackld.cvalid", 32'(frame_valid), 32'h1);

    // Watchdog expiry discards the partial frame
    do_reset();
    seg(5'b00001, 8'h3F, 10, 1'b0, 1'b0);
    seg(5'b00010, 8'h06, 10, 1'b0, 1'b0);
    SEG_SEL = '0; SEG_DATA = '0;
    b0 = cyc;
    while (cyc < m_last + TMO - 1) tick();
    check("wd.before", 32'(scan_lost), 32'h0);
    tick();
    check("wd.at", 32'(scan_lost), 32'h1);
    while (cyc - b0 < 70) tick();
    last_drv = '0;
    chk_all("wd.blank");
    for (int i = 2; i < 5; i++) seg(5'(1 << i), fb[8*i +: 8], 10, 1'b0, 1'b0);
    chk_all("wd.part");
    check("wd.cvalid0", 32'(frame_valid), 32'h0);
    for (int i = 0; i < 2; i++) seg(5'(1 << i), fb[8*i +: 8], 10, 1'b0, 1'b0);
    chk_all("wd.full");
    check("wd.cvalid1", 32'(frame_valid), 32'h1);
    check("wd.clost", 32'(scan_lost), 32'h0);

    // Reset after three captures discards them
    for (int i = 0; i < 3; i++) seg(5'(1 << i), fa[8*i +: 8], 10, 1'b0, 1'b0);
    do_reset();
    for (int i = 3; i < 5; i++) seg(5'(1 << i), fa[8*i +: 8], 10, 1'b0, 1'b0);
    chk_all("rstp.part");
    check("rstp.cvalid0", 32'(frame_valid), 32'h0);
    for (int i = 0; i < 3; i++) seg(5'(1 << i), fa[8*i +: 8], 10, 1'b0, 1'b0);
    chk_all("rstp.full");
    check("rstp.const", 32'(digits), 32'h43210);

    // Randomized segments
    nocap = 0;
    for (int n = 0; n < 400; n++) begin
      do begin
        kind = $urandom_range(0, 9);
        if (nocap >= 2) kind = 0;
        capt = 0;
        if (kind <= 6) begin
          sel = 5'(1 << $urandom_range(0, 4));
          capt = (nocap >= 2) || ($urandom_range(0, 2) != 0);
        end else if (kind == 7) begin
          sel = '0;
        end else begin
          do sel = 5'($urandom_range(0, 31)); while ($countones(sel) < 2);
        end
        if ($urandom_range(0, 3) == 0) data = 8'($urandom_range(0, 255));
        else if ($urandom_range(0, 10) == 0) data = {1'($urandom_range(0, 1)), 7'h00};
        else data = {1'($urandom_range(0, 1)), pat[$urandom_range(0, 9)]};
      end while ({sel, data} == last_drv);
      len = capt ? $urandom_range(8, 12) : $urandom_range(1, 3);
      nocap = capt ? 0 : nocap + 1;
      seg(sel, data, len, ($urandom_range(0, 3) == 0), capt && ($urandom_range(0, 5) == 0));
      chk_all("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
